// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a selectable standard or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DW        = 8,
  parameter int AW        = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  generate
    if (AW < 1 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_param_check
      $error("sync_fifo_param: illegal AW/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg, underflow_reg;
  logic          rd_ok, wr_ok;

  // Every flag decodes from the registered count only, never from this cycle's requests.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A pop frees the slot a simultaneous write needs, so full does not block that write.
  assign rd_ok = re && !empty;
  assign wr_ok = we && (!full || rd_ok);

  always_comb begin
    count_next = count_reg;
    if (wr_ok && !rd_ok) begin
      count_next = count_reg + ONE_C;
    end else if (rd_ok && !wr_ok) begin
      count_next = count_reg - ONE_C;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= we && !wr_ok;
      underflow_reg <= re && !rd_ok;
      if (wr_ok) wptr_reg <= wptr_reg + PTR_ONE_C;
      if (rd_ok) rptr_reg <= rptr_reg + PTR_ONE_C;
    end
  end

  // Storage is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) mem[wptr_reg] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata  = mem[rptr_reg];
      assign rvalid = !empty;
    end else begin : g_std
      logic [DW-1:0] rdata_reg;
      logic          rvalid_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_ok;
          if (rd_ok) rdata_reg <= mem[rptr_reg];
        end
      end

      assign rdata  = rdata_reg;
      assign rvalid = rvalid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance, each compared every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          we0 = 1'b0, re0 = 1'b0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] rdata0;
  logic          rvalid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [AW:0]   count0;

  logic          we1 = 1'b0, re1 = 1'b0;
  logic [DW-1:0] wdata1 = '0;
  logic [DW-1:0] rdata1;
  logic          rvalid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0]   count1;

  int n_checks = 0;
  int n_errors = 0;
  bit started = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] m_rdata0 = '0;
  bit m_rvalid0 = 0, m_ovf0 = 0, m_unf0 = 0, m_ovf1 = 0, m_unf1 = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DW(DW), .AW(AW), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .we(we0), .wdata(wdata0), .re(re0),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DW(DW), .AW(AW), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .we(we1), .wdata(wdata1), .re(re1),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge: the queue holds the FIFO contents in order.
  task automatic model_edge();
    bit rd, wr;
    if (!rst) begin
      q0.delete(); q1.delete();
      m_rdata0 = '0; m_rvalid0 = 0;
      m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
    end else begin
      rd = re0 && (q0.size() > 0);
      wr = we0 && ((q0.size() < DEPTH) || rd);
      m_rvalid0 = rd;
      if (rd) m_rdata0 = q0.pop_front();
      if (wr) q0.push_back(wdata0);
      m_ovf0 = we0 && !wr;
      m_unf0 = re0 && !rd;

      rd = re1 && (q1.size() > 0);
      wr = we1 && ((q1.size() < DEPTH) || rd);
      if (rd) void'(q1.pop_front());
      if (wr) q1.push_back(wdata1);
      m_ovf1 = we1 && !wr;
      m_unf1 = re1 && !rd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("count0", count0, q0.size());
      chk("empty0", empty0, q0.size() == 0);
      chk("full0", full0, q0.size() == DEPTH);
      chk("almost_full0", af0, q0.size() >= 6);
      chk("almost_empty0", ae0, q0.size() <= 1);
      chk("rvalid0", rvalid0, m_rvalid0);
      chk("rdata0", rdata0, m_rdata0);
      chk("overflow0", ovf0, m_ovf0);
      chk("underflow0", unf0, m_unf0);
      chk("count1", count1, q1.size());
      chk("empty1", empty1, q1.size() == 0);
      chk("full1", full1, q1.size() == DEPTH);
      chk("almost_full1", af1, q1.size() >= 6);
      chk("almost_empty1", ae1, q1.size() <= 1);
      chk("rvalid1", rvalid1, q1.size() != 0);
      if (q1.size() != 0) chk("rdata1", rdata1, q1[0]);
      chk("overflow1", ovf1, m_ovf1);
      chk("underflow1", unf1, m_unf1);
    end
  end

  initial begin
    int pw, pr;
    logic [DW-1:0] v;

    @(negedge clk);
    tick();
    started = 1'b1;
    tick();
    rst = 1'b1;
    // Reset state
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_almost_empty", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_almost_full", af0, 0);
    chk("rst_rdata", rdata0, 8'h00);
    chk("rst_rvalid", rvalid0, 0);
    chk("rst_errors", {ovf0, unf0}, 2'b00);

    // Fill, then overflow
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1; v = 8'h11 * (i + 1); wdata0 = v;
      tick();
      chk("fill_count", count0, i + 1);
      chk("fill_almost_empty", ae0, (i + 1) <= 1);
      chk("fill_almost_full", af0, (i + 1) >= 6);
      chk("fill_full", full0, i == 7);
    end
    wdata0 = 8'h99;
    tick();
    chk("ovf_pulse", ovf0, 1);
    chk("ovf_count", count0, 8);
    we0 = 1'b0;
    tick();
    chk("ovf_clear", ovf0, 0);

    // Drain, then underflow
    for (int i = 0; i < 8; i++) begin
      re0 = 1'b1;
      tick();
      v = 8'h11 * (i + 1);
      chk("drain_rvalid", rvalid0, 1);
      chk("drain_rdata", rdata0, v);
    end
    tick();
    chk("unf_pulse", unf0, 1);
    chk("unf_rvalid", rvalid0, 0);
    chk("unf_rdata_hold", rdata0, 8'h88);
    chk("unf_empty", empty0, 1);
    re0 = 1'b0;

    // Simultaneous access while full
    for (int i = 0; i < 8; i++) begin
      we0 = 1'b1; v = 8'h11 * (i + 1); wdata0 = v;
      tick();
    end
    re0 = 1'b1; wdata0 = 8'hAB;
    tick();
    chk("full_rw_ovf", ovf0, 0);
    chk("full_rw_count", count0, 8);
    chk("full_rw_rdata", rdata0, 8'h11);
    we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) chk("wrap_last_rdata", rdata0, 8'hAB);
    end

    // Simultaneous access while empty
    we0 = 1'b1; re0 = 1'b1; wdata0 = 8'h5C;
    tick();
    chk("empty_rw_unf", unf0, 1);
    chk("empty_rw_count", count0, 1);
    we0 = 1'b0;
    tick();
    chk("empty_rw_readback", rdata0, 8'h5C);
    re0 = 1'b0;
    tick();

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      we0 = 1'b1; v = 8'h60 + 8'(i); wdata0 = v;
      tick();
    end
    chk("pre_rst_count", count0, 5);
    rst = 1'b0; re0 = 1'b1;
    tick();
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_rvalid", rvalid0, 0);
    chk("mid_rst_errors", {ovf0, unf0}, 2'b00);
    rst = 1'b1; re0 = 1'b0; wdata0 = 8'h7E;
    tick();
    we0 = 1'b0; re0 = 1'b1;
    tick();
    chk("post_rst_first", rdata0, 8'h7E);
    re0 = 1'b0;
    tick();

    // First-word-fall-through instance
    we1 = 1'b1; wdata1 = 8'hA5;
    tick();
    chk("fwft_empty", empty1, 0);
    chk("fwft_rvalid", rvalid1, 1);
    chk("fwft_rdata", rdata1, 8'hA5);
    wdata1 = 8'h3C; re1 = 1'b1;
    tick();
    chk("fwft_next_rdata", rdata1, 8'h3C);
    chk("fwft_count", count1, 1);
    we1 = 1'b0; re1 = 1'b0;
    tick();

    // Randomized traffic with shifting write/read bias and rare resets
    for (int i = 0; i < 1200; i++) begin
      if (i % 60 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      rst = ($urandom_range(0, 199) != 0);
      we0 = ($urandom_range(0, 99) < pw);
      re0 = ($urandom_range(0, 99) < pr);
      wdata0 = DW'($urandom);
      we1 = ($urandom_range(0, 99) < pr);
      re1 = ($urandom_range(0, 99) < pw);
      wdata1 = DW'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
